axis_uart_fifo_core: RTL and testbench

Parametrised AXI-Stream UART core: full-duplex TX and RX serialisers, each behind its own synchronous FIFO, with a runtime baud divisor. This is the next-generation core under the `tt_um_top_axis_uart` top. It generalises the fixed 8N1 unbuffered path to configurable data width, FIFO depth and divisor, and adds error reporting and optional parity.

---
 rtl/axis_uart_fifo_core_if.sv | 16 +
 rtl/axis_uart_fifo_core.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_axis_uart_fifo_core.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_fifo_core_if.sv
// axis_uart_fifo_core_if
//   One AXI-Stream channel (tdata/tvalid/tready) used for both the TX input
//   stream and the RX output stream of axis_uart_fifo_core.
//   Parameters: DATA_BITS - payload width of tdata.
//   Modports:   master - drives tdata/tvalid, receives tready
//               slave  - receives tdata/tvalid, drives tready
interface axis_uart_fifo_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_fifo_core.sv
// axis_uart_fifo_core
//   Full-duplex UART with an AXI-Stream front end. Each direction is buffered
//   by its own FIFO_DEPTH-entry synchronous FIFO. The baud divisor is sampled
//   at runtime, once per frame, and clamped to a minimum of 4 clocks per bit.
//   Optional feature macro: AXIS_UART_PARITY_EN adds an even-parity bit after
//   the data bits on TX and checks it on RX.
// Ports:
//   clk, rst    - single rising-edge clock, asynchronous active-high reset
//   baud_div    - clocks per bit
//   s_axis      - TX byte stream in (tready = TX FIFO not full)
//   m_axis      - RX byte stream out (tvalid = RX FIFO not empty)
//   uart_txd    - serial out, idle high
//   uart_rxd    - serial in, asynchronous to clk
//   tx_busy     - a TX frame is on the line
//   frame_err   - one-cycle pulse: bad stop bit (or bad parity)
//   rx_overrun  - one-cycle pulse: received byte dropped, RX FIFO full
module axis_uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  axis_uart_fifo_core_if.slave  s_axis,
  axis_uart_fifo_core_if.master m_axis,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic                 tx_busy,
  output logic                 frame_err,
  output logic                 rx_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef AXIS_UART_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;

  localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);
  localparam logic [AW:0]          PTR_ONE  = (AW + 1)'(1);

  logic [DIV_WIDTH-1:0] div_eff;
  assign div_eff = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wr, tx_rd;
  logic                 tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty      = (tx_wr == tx_rd);
  assign tx_full       = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign s_axis.tready = !tx_full;
  assign tx_push       = s_axis.tvalid && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= s_axis.tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]           tx_state;
  logic [DIV_WIDTH-1:0] tx_div, tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_bit_end, tx_line;
`ifdef AXIS_UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_bit_end = (tx_cnt == '0);
  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop = !tx_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_bit_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_div   <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef AXIS_UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state <= ST_START;
      tx_div   <= div_eff;
      tx_cnt   <= div_eff - CNT_ONE;
      tx_shift <= tx_mem[tx_rd[AW-1:0]];
`ifdef AXIS_UART_PARITY_EN
      tx_par   <= ^tx_mem[tx_rd[AW-1:0]];
`endif
    end else if (tx_state != ST_IDLE) begin
      if (!tx_bit_end) begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end else begin
        tx_cnt <= tx_div - CNT_ONE;
        case (tx_state)
          ST_START: begin
            tx_state <= ST_DATA;
            tx_bit   <= '0;
          end
          ST_DATA: begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BIT_ONE;
            if (tx_bit == LAST_BIT) begin
`ifdef AXIS_UART_PARITY_EN
              tx_state <= ST_PARITY;
`else
              tx_state <= ST_STOP;
`endif
            end
          end
`ifdef AXIS_UART_PARITY_EN
          ST_PARITY: tx_state <= ST_STOP;
`endif
          default: tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_shift[0];
`ifdef AXIS_UART_PARITY_EN
      ST_PARITY: tx_line = tx_par;
`endif
      default:   tx_line = 1'b1;
    endcase
  end

  // The line and busy flag are registered together, so tx_busy covers exactly
  // the frame as seen on uart_txd. The FIFO-not-empty-while-idle case lasts
  // at most one cycle because the FSM pops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      uart_txd <= tx_line;
      tx_busy  <= (tx_state != ST_IDLE);
    end
  end

  // ---------------- RX synchroniser ----------------
  logic rx_s1, rx_s2, rx_prev, rx_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wr, rx_rd;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift;

  assign rx_empty      = (rx_wr == rx_rd);
  assign rx_full       = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign m_axis.tvalid = !rx_empty;
  // Gated so tdata reads 0 out of reset without resetting the storage.
  assign m_axis.tdata  = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
  assign rx_pop        = !rx_empty && m_axis.tready;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
    end
  end

  // ---------------- RX FSM ----------------
  logic [2:0]           rx_state;
  logic [DIV_WIDTH-1:0] rx_div, rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic                 rx_par_bad;
`ifdef AXIS_UART_PARITY_EN
  logic                 rx_par_bad_q;
  assign rx_par_bad = rx_par_bad_q;
`else
  assign rx_par_bad = 1'b0;
`endif

  assign rx_push = (rx_state == ST_STOP) && (rx_cnt == '0) && rx_s2 && !rx_par_bad && !rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= ST_IDLE;
      rx_div     <= '0;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef AXIS_UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state <= ST_START;
            rx_div   <= div_eff;
            // Half a bit to land the start-bit check at mid-bit.
            rx_cnt   <= (div_eff >> 1) - CNT_ONE;
          end
        end
        // After a framing error, hold off until the line is idle again so a
        // long low (break) is not mistaken for a new start bit.
        ST_WAIT: begin
          if (rx_s2) rx_state <= ST_IDLE;
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_cnt <= rx_div - CNT_ONE;
            case (rx_state)
              ST_START: begin
                if (rx_s2) begin
                  rx_state <= ST_IDLE;
                end else begin
                  rx_state <= ST_DATA;
                  rx_bit   <= '0;
                end
              end
              ST_DATA: begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + BIT_ONE;
                if (rx_bit == LAST_BIT) begin
`ifdef AXIS_UART_PARITY_EN
                  rx_state <= ST_PARITY;
`else
                  rx_state <= ST_STOP;
`endif
                end
              end
`ifdef AXIS_UART_PARITY_EN
              ST_PARITY: begin
                rx_par_bad_q <= rx_s2 ^ (^rx_shift);
                rx_state     <= ST_STOP;
              end
`endif
              default: begin
                if (rx_s2 && !rx_par_bad) begin
                  rx_overrun <= rx_full;
                  rx_state   <= ST_IDLE;
                end else begin
                  frame_err <= 1'b1;
                  rx_state  <= rx_s2 ? ST_IDLE : ST_WAIT;
                end
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_uart_fifo_core.sv
// tb_axis_uart_fifo_core
//   Directed self-checking bench for axis_uart_fifo_core (DATA_BITS=8,
//   FIFO_DEPTH=4). Also builds with AXIS_UART_PARITY_EN defined.
`timescale 1ns/1ps
module tb_axis_uart_fifo_core;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_WIDTH  = 16;
`ifdef AXIS_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DIV_WIDTH-1:0] baud_div = 16'd16;
  logic                 rx_drv = 1'b1;
  logic                 loopback = 1'b0;
  logic                 uart_txd, uart_rxd, tx_busy, frame_err, rx_overrun;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fe_seen      = 0;
  int ov_seen      = 0;

  axis_uart_fifo_core_if #(.DATA_BITS(DATA_BITS)) s_axis ();
  axis_uart_fifo_core_if #(.DATA_BITS(DATA_BITS)) m_axis ();

  assign uart_rxd = loopback ? uart_txd : rx_drv;

  axis_uart_fifo_core #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_div  (baud_div),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd),
    .tx_busy   (tx_busy),
    .frame_err (frame_err),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Expected TX line level k cycles after the edge that accepted byte b.
  function automatic logic tx_expect(input int k, input logic [7:0] b, input int d);
    int pos;
    if (k < 2) return 1'b1;
    pos = (k - 2) / d;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef AXIS_UART_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic watch();
    if (frame_err === 1'b1) fe_seen++;
    if (rx_overrun === 1'b1) ov_seen++;
  endtask

  task automatic rx_hold(input logic v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      watch();
      rx_drv = v;
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic bad_par, input int d);
    rx_hold(1'b0, d);
    for (int i = 0; i < 8; i++) rx_hold(b[i], d);
`ifdef AXIS_UART_PARITY_EN
    rx_hold((^b) ^ bad_par, d);
`else
    if (bad_par) rx_hold(1'b1, 0);
`endif
    rx_hold(stop, d);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_compared++; if (uart_txd !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_txd: got %b want 1", uart_txd); end
    n_compared++; if (s_axis.tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_tready: got %b want 1", s_axis.tready); end
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_axis.tvalid); end
    n_compared++; if (m_axis.tdata !== 8'h00) begin n_mismatched++; $display("[TB] FAIL reset_tdata: got %h want 00", m_axis.tdata); end
    n_compared++; if (tx_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", tx_busy); end
    n_compared++; if (frame_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
    n_compared++; if (rx_overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_overrun: got %b want 0", rx_overrun); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_shape();
    logic exp;
    int   busy_cnt = 0;
    baud_div = 16'd16;
    @(negedge clk);
    s_axis.tdata  = 8'hA5;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    for (int k = 0; k < 180; k++) begin
      exp = tx_expect(k, 8'hA5, 16);
      n_compared++;
      if (uart_txd !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL tx_shape[%0d]: got %b want %b", k, uart_txd, exp);
      end
      if (tx_busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    n_compared++;
    if (busy_cnt != 16 * FRAME_BITS) begin
      n_mismatched++;
      $display("[TB] FAIL tx_busy_len: got %0d want %0d", busy_cnt, 16 * FRAME_BITS);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    logic [7:0] got [3];
    int   n_rx = 0, busy_cnt = 0, rises = 0;
    logic busy_prev = 1'b0;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int j = 0; j < 3; j++) got[j] = 8'hXX;
    baud_div = 16'd8;
    loopback = 1'b1;
    m_axis.tready = 1'b1;
    fe_seen = 0; ov_seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_axis.tvalid === 1'b1) begin
        if (n_rx < 3) got[n_rx] = m_axis.tdata;
        n_rx++;
      end
      watch();
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_busy === 1'b1 && !busy_prev) rises++;
      busy_prev = tx_busy;
      if (i < 3) begin
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = bytes[i];
      end else begin
        s_axis.tvalid = 1'b0;
      end
    end
    m_axis.tready = 1'b0;
    loopback = 1'b0;
    n_compared++; if (n_rx != 3) begin n_mismatched++; $display("[TB] FAIL loop_count: got %0d want 3", n_rx); end
    for (int j = 0; j < 3; j++) begin
      n_compared++;
      if (got[j] !== bytes[j]) begin n_mismatched++; $display("[TB] FAIL loop_byte%0d: got %h want %h", j, got[j], bytes[j]); end
    end
    n_compared++; if (fe_seen != 0) begin n_mismatched++; $display("[TB] FAIL loop_frame_err: got %0d want 0", fe_seen); end
    n_compared++; if (ov_seen != 0) begin n_mismatched++; $display("[TB] FAIL loop_overrun: got %0d want 0", ov_seen); end
    n_compared++; if (busy_cnt != 3 * 8 * FRAME_BITS) begin n_mismatched++; $display("[TB] FAIL loop_busy_len: got %0d want %0d", busy_cnt, 3 * 8 * FRAME_BITS); end
    n_compared++; if (rises != 1) begin n_mismatched++; $display("[TB] FAIL loop_gap: busy rose %0d times want 1", rises); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h55;
    baud_div = 16'd8;
    m_axis.tready = 1'b0;
    fe_seen = 0; ov_seen = 0;
    rx_hold(1'b1, 8);
    for (int j = 0; j < 5; j++) rx_frame(exp[j], 1'b1, 1'b0, 8);
    rx_hold(1'b1, 24);
    n_compared++; if (ov_seen != 1) begin n_mismatched++; $display("[TB] FAIL ovr_pulses: got %0d want 1", ov_seen); end
    n_compared++; if (fe_seen != 0) begin n_mismatched++; $display("[TB] FAIL ovr_frame_err: got %0d want 0", fe_seen); end
    @(negedge clk);
    m_axis.tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_compared++;
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== exp[j]) begin
        n_mismatched++;
        $display("[TB] FAIL ovr_drain%0d: got v=%b d=%h want v=1 d=%h", j, m_axis.tvalid, m_axis.tdata, exp[j]);
      end
      @(negedge clk);
    end
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ovr_empty: got %b want 0", m_axis.tvalid); end
    m_axis.tready = 1'b0;
  endtask

  task automatic test_errors();
    baud_div = 16'd8;
    fe_seen = 0; ov_seen = 0;
    rx_frame(8'h5A, 1'b0, 1'b0, 8);
    rx_hold(1'b0, 8);
    rx_hold(1'b1, 24);
    n_compared++; if (fe_seen != 1) begin n_mismatched++; $display("[TB] FAIL ferr_pulses: got %0d want 1", fe_seen); end
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ferr_push: tvalid %b want 0", m_axis.tvalid); end
    n_compared++; if (ov_seen != 0) begin n_mismatched++; $display("[TB] FAIL ferr_overrun: got %0d want 0", ov_seen); end

    baud_div = 16'd16;
    fe_seen = 0;
    rx_hold(1'b0, 3);
    rx_hold(1'b1, 40);
    n_compared++; if (fe_seen != 0) begin n_mismatched++; $display("[TB] FAIL glitch_pulse: got %0d want 0", fe_seen); end
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL glitch_push: tvalid %b want 0", m_axis.tvalid); end

    rx_frame(8'hC3, 1'b1, 1'b0, 16);
    rx_hold(1'b1, 48);
    n_compared++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 8'hC3) begin
      n_mismatched++;
      $display("[TB] FAIL post_glitch_rx: got v=%b d=%h want v=1 d=c3", m_axis.tvalid, m_axis.tdata);
    end
    m_axis.tready = 1'b1;
    @(negedge clk);
    m_axis.tready = 1'b0;
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_glitch_pop: tvalid %b want 0", m_axis.tvalid); end
  endtask

  task automatic test_reset_mid_frame();
    int low_cnt = 0, busy_cnt = 0;
    baud_div = 16'd16;
    @(negedge clk);
    s_axis.tvalid = 1'b1; s_axis.tdata = 8'hF7;
    @(negedge clk);
    s_axis.tdata = 8'h12;
    @(negedge clk);
    s_axis.tdata = 8'h34;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    repeat (68) @(negedge clk);
    n_compared++; if (uart_txd !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmf_bit3: got %b want 0", uart_txd); end
    #1 rst = 1'b1;
    #1;
    n_compared++; if (uart_txd !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmf_txd_async: got %b want 1", uart_txd); end
    n_compared++; if (tx_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmf_busy_async: got %b want 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_cnt++;
      if (tx_busy !== 1'b0) busy_cnt++;
    end
    n_compared++; if (low_cnt != 0) begin n_mismatched++; $display("[TB] FAIL rmf_line_idle: low %0d cycles want 0", low_cnt); end
    n_compared++; if (busy_cnt != 0) begin n_mismatched++; $display("[TB] FAIL rmf_busy: high %0d cycles want 0", busy_cnt); end
    n_compared++; if (s_axis.tready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmf_tready: got %b want 1", s_axis.tready); end
  endtask

`ifdef AXIS_UART_PARITY_EN
  task automatic test_parity();
    baud_div = 16'd16;
    @(negedge clk);
    s_axis.tvalid = 1'b1; s_axis.tdata = 8'h07;
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    repeat (154) @(negedge clk);
    n_compared++; if (uart_txd !== 1'b1) begin n_mismatched++; $display("[TB] FAIL par_tx_bit: got %b want 1", uart_txd); end
    repeat (40) @(negedge clk);
    baud_div = 16'd8;
    fe_seen = 0;
    rx_frame(8'h07, 1'b1, 1'b1, 8);
    rx_hold(1'b1, 24);
    n_compared++; if (fe_seen != 1) begin n_mismatched++; $display("[TB] FAIL par_rx_err: got %0d want 1", fe_seen); end
    n_compared++; if (m_axis.tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL par_rx_drop: tvalid %b want 0", m_axis.tvalid); end
  endtask
`endif

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_tx_shape();
    test_loopback();
    test_overrun();
    test_errors();
    test_reset_mid_frame();
`ifdef AXIS_UART_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
